// File: rtl/complex_div_pkg.sv
// Shared types, widths and helpers for the complex divider and its serial divider.
package complex_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAC_DEF = 8;
  localparam int NUM_W    = 33;
  localparam int DEN_W    = 32;
  localparam int Q_W      = NUM_W + FRAC_DEF;

  // Output range of a 16-bit signed quotient part, as values and as magnitudes.
  localparam logic signed [15:0] SAT_MAX     = 16'sh7fff;
  localparam logic signed [15:0] SAT_MIN     = 16'sh8000;
  localparam logic [63:0]        SAT_MAX_MAG = 64'd32767;
  localparam logic [63:0]        SAT_MIN_MAG = 64'd32768;

  typedef struct packed {
    logic signed [15:0] val;
    logic               sat;
  } sat_res_t;

  // Magnitude of a 16-bit signed value; -32768 maps to 16'h8000 read as unsigned.
  function automatic logic [15:0] abs16(input logic signed [15:0] v);
    return v[15] ? 16'(-v) : 16'(v);
  endfunction

  // Apply the sign to an unsigned quotient magnitude and clamp to 16-bit signed.
  function automatic sat_res_t saturate(input logic [63:0] mag, input logic neg);
    sat_res_t r;
    r.sat = 1'b0;
    if (neg) begin
      if (mag > SAT_MIN_MAG) begin
        r.val = SAT_MIN;
        r.sat = 1'b1;
      end else begin
        r.val = -$signed(mag[15:0]);
      end
    end else begin
      if (mag > SAT_MAX_MAG) begin
        r.val = SAT_MAX;
        r.sat = 1'b1;
      end else begin
        r.val = $signed(mag[15:0]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_divider_if.sv
// Request/result bundle of the complex divider: operands and valid in, quotient and status out.
interface complex_divider_if;
  logic signed [15:0] input1;
  logic signed [15:0] input2;
  logic signed [15:0] input3;
  logic signed [15:0] input4;
  logic               valid;
  logic               busy;
  logic signed [15:0] quot_re;
  logic signed [15:0] quot_im;
  logic               out_valid;
  logic               div_zero;
  logic               sat;

  modport master (
    output input1, input2, input3, input4, valid,
    input  busy, quot_re, quot_im, out_valid, div_zero, sat
  );

  modport slave (
    input  input1, input2, input3, input4, valid,
    output busy, quot_re, quot_im, out_valid, div_zero, sat
  );
endinterface

// File: rtl/udiv_serial.sv
// Unsigned restoring divider, one quotient bit per step; sequencing comes from the parent.
module udiv_serial
  import complex_div_pkg::*;
#(
  parameter int QW = Q_W,
  parameter int DW = DEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic          last,
  input  logic [QW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  // Partial remainder stays below the divisor, so DW bits hold it.
  logic [DW-1:0] rem;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [QW-1:0] acc;
  logic [DW:0]   trial;
  logic          fits;

  // Trial subtraction for the current step.
  always_comb begin
    trial = {rem, acc[QW-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  // Load operands on start, then shift/subtract once per step.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      acc <= '0;
    end else if (start) begin
      rem <= '0;
      acc <= dividend;
    end else if (step) begin
      rem <= fits ? DW'(trial - {1'b0, divisor}) : trial[DW-1:0];
      acc <= {acc[QW-2:0], fits};
    end
  end

  assign quotient = acc;
  assign done     = step & last;

endmodule

// File: rtl/complex_divider.sv
// Complex division (a+bi)/(c+di) with signed fixed-point quotient, via two serial dividers.
module complex_divider
  import complex_div_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
) (
  input logic              clk,
  input logic              rst,
  complex_divider_if.slave bus
);

  localparam int QW = NUM_W + FRAC;
  localparam int CNT_W = $clog2(QW + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QW - 1);

  state_t state, next_state;

  logic signed [15:0]      a_q, b_q, c_q, d_q;
  logic signed [NUM_W-1:0] a_x, b_x, c_x, d_x;
  logic signed [NUM_W-1:0] num_re_c, num_im_c;
  logic signed [NUM_W-1:0] num_re_q, num_im_q;
  logic [15:0]             c_abs, d_abs;
  logic [DEN_W-1:0]        den_c, den_q;
  logic [NUM_W-1:0]        mag_re, mag_im;
  logic [CNT_W-1:0]        iter_cnt;
  logic                    div_start, div_step, div_last, done_re, done_im;
  logic [QW-1:0]           q_re, q_im;
  sat_res_t                res_re, res_im;

  logic signed [15:0]      quot_re_q, quot_im_q;
  logic                    out_valid_q, div_zero_q, sat_q;

  // Operands widened to 33 bits so products and their sums never overflow.
  assign a_x = {{(NUM_W-16){a_q[15]}}, a_q};
  assign b_x = {{(NUM_W-16){b_q[15]}}, b_q};
  assign c_x = {{(NUM_W-16){c_q[15]}}, c_q};
  assign d_x = {{(NUM_W-16){d_q[15]}}, d_q};

  assign num_re_c = a_x * c_x + b_x * d_x;
  assign num_im_c = b_x * c_x - a_x * d_x;

  // Squares from magnitudes keep den exact up to 2^31 in 32 unsigned bits.
  assign c_abs = abs16(c_q);
  assign d_abs = abs16(d_q);
  assign den_c = DEN_W'(c_abs) * DEN_W'(c_abs) + DEN_W'(d_abs) * DEN_W'(d_abs);

  assign mag_re = num_re_c[NUM_W-1] ? NUM_W'(-num_re_c) : NUM_W'(num_re_c);
  assign mag_im = num_im_c[NUM_W-1] ? NUM_W'(-num_im_c) : NUM_W'(num_im_c);

  // Both dividers share the divisor and one iteration counter.
  assign div_start = (state == MULT);
  assign div_step  = (state == DIV);
  assign div_last  = (iter_cnt == LAST_ITER);

  udiv_serial #(.QW(QW), .DW(DEN_W)) u_div_re (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .step     (div_step),
    .last     (div_last),
    .dividend ({mag_re, {FRAC{1'b0}}}),
    .divisor  (den_q),
    .quotient (q_re),
    .done     (done_re)
  );

  udiv_serial #(.QW(QW), .DW(DEN_W)) u_div_im (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .step     (div_step),
    .last     (div_last),
    .dividend ({mag_im, {FRAC{1'b0}}}),
    .divisor  (den_q),
    .quotient (q_im),
    .done     (done_im)
  );

  assign res_re = saturate(64'(q_re), num_re_q < 0);
  assign res_im = saturate(64'(q_im), num_im_q < 0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.valid) next_state = MULT;
      MULT: next_state = (c_q == '0 && d_q == '0) ? DONE : DIV;
      DIV:  if (done_re & done_im) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, products/denominator and iteration count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      num_re_q <= '0;
      num_im_q <= '0;
      den_q    <= '0;
      iter_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.valid) begin
          a_q <= bus.input1;
          b_q <= bus.input2;
          c_q <= bus.input3;
          d_q <= bus.input4;
        end
        MULT: begin
          num_re_q <= num_re_c;
          num_im_q <= num_im_c;
          den_q    <= den_c;
          iter_cnt <= '0;
        end
        DIV:     iter_cnt <= iter_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Results and status register in DONE and hold until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_re_q   <= '0;
      quot_im_q   <= '0;
      div_zero_q  <= 1'b0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state == DONE);
      if (state == DONE) begin
        if (den_q == '0) begin
          quot_re_q  <= '0;
          quot_im_q  <= '0;
          div_zero_q <= 1'b1;
          sat_q      <= 1'b0;
        end else begin
          quot_re_q  <= res_re.val;
          quot_im_q  <= res_im.val;
          div_zero_q <= 1'b0;
          sat_q      <= res_re.sat | res_im.sat;
        end
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.quot_re   = quot_re_q;
  assign bus.quot_im   = quot_im_q;
  assign bus.out_valid = out_valid_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_complex_divider.sv
// Directed bench for complex_divider (FRAC=8) with hand-computed expected quotients.
module tb_complex_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  complex_divider_if bus ();

  complex_divider #(.FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int     checks = 0;
  int     errors = 0;
  int     r_edge;
  int     r_pulses;
  longint r_re, r_im, r_sat, r_dz;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present operands with valid; they are captured on the next rising edge (edge 0).
  task automatic issue(input int a, input int b, input int c, input int d);
    bus.input1 = 16'(a);
    bus.input2 = 16'(b);
    bus.input3 = 16'(c);
    bus.input4 = 16'(d);
    bus.valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid  = 1'b0;
  endtask

  // Observe up to max edges after the capture edge, counting out_valid pulses and
  // recording the first one; optionally drive a stray request sampled at edge inj.
  task automatic watch(input int max, input bit stop, input int inj,
                       input int ia, input int ib, input int ic, input int id);
    r_edge   = -1;
    r_pulses = 0;
    r_re     = 0;
    r_im     = 0;
    r_sat    = 0;
    r_dz     = 0;
    for (int e = 1; e <= max && !(stop && r_pulses > 0); e++) begin
      if (e == inj) begin
        bus.input1 = 16'(ia);
        bus.input2 = 16'(ib);
        bus.input3 = 16'(ic);
        bus.input4 = 16'(id);
        bus.valid  = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.valid = 1'b0;
      if (bus.out_valid) begin
        r_pulses++;
        if (r_edge < 0) begin
          r_edge = e;
          r_re   = bus.quot_re;
          r_im   = bus.quot_im;
          r_sat  = bus.sat;
          r_dz   = bus.div_zero;
        end
      end
    end
  endtask

  task automatic run(input string tag, input int a, input int b, input int c, input int d,
                     input int exp_edge, input int exp_re, input int exp_im,
                     input int exp_sat, input int exp_dz);
    issue(a, b, c, d);
    check({tag, "_busy"}, bus.busy, 1);
    watch(60, 1'b1, 0, 0, 0, 0, 0);
    check({tag, "_edge"}, r_edge, exp_edge);
    check({tag, "_re"}, r_re, exp_re);
    check({tag, "_im"}, r_im, exp_im);
    check({tag, "_sat"}, r_sat, exp_sat);
    check({tag, "_dz"}, r_dz, exp_dz);
  endtask

  initial begin
    rst        = 1'b1;
    bus.valid  = 1'b0;
    bus.input1 = '0;
    bus.input2 = '0;
    bus.input3 = '0;
    bus.input4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_re", bus.quot_re, 0);
    check("rst_im", bus.quot_im, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_sat", bus.sat, 0);
    @(negedge clk);
    rst = 1'b0;

    // (10+5i)/(1+2i) = 4-3i -> 1024, -768 at FRAC=8
    run("basic", 10, 5, 1, 2, 43, 1024, -768, 0, 0);

    // Back-to-back: request on the edge right after the out_valid cycle is accepted,
    // the strobe lasts one cycle and the previous result holds meanwhile.
    issue(1, 0, 3, 0);
    check("b2b_busy", bus.busy, 1);
    check("pulse_width", bus.out_valid, 0);
    check("hold_re", bus.quot_re, 1024);
    check("hold_im", bus.quot_im, -768);
    watch(60, 1'b1, 0, 0, 0, 0, 0);
    check("third_edge", r_edge, 43);
    check("third_re", r_re, 85);
    check("third_im", r_im, 0);

    run("neg_third", -1, 0, 3, 0, 43, -85, 0, 0, 0);
    run("neg_7_2", -7, 0, 2, 0, 43, -896, 0, 0, 0);
    run("sat_pos", 32767, 0, 1, 0, 43, 32767, 0, 1, 0);
    run("sat_neg", -32768, 0, 1, 0, 43, -32768, 0, 1, 0);
    run("dz", 100, 100, 0, 0, 2, 0, 0, 0, 1);
    // num_re = 2^31, num_im = 0, den = 2^31 -> 1.0
    run("extreme", -32768, -32768, -32768, -32768, 43, 256, 0, 0, 0);
    // (3+4i)/(1-1i) = -0.5+3.5i
    run("mixed", 3, 4, 1, -1, 43, -128, 896, 0, 0);

    // A request at edge 10 of a running operation is dropped, not queued.
    issue(10, 5, 1, 2);
    watch(60, 1'b0, 10, 1, 0, 3, 0);
    check("busy_pulses", r_pulses, 1);
    check("busy_edge", r_edge, 43);
    check("busy_re", r_re, 1024);
    check("busy_im", r_im, -768);

    // Reset at edge 20 aborts the operation and clears outputs at once.
    issue(1, 0, 3, 0);
    watch(19, 1'b0, 0, 0, 0, 0, 0);
    check("abort_pre_pulses", r_pulses, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_re", bus.quot_re, 0);
    check("abort_im", bus.quot_im, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(3, 4, 1, -1);
    watch(60, 1'b0, 0, 0, 0, 0, 0);
    check("post_rst_pulses", r_pulses, 1);
    check("post_rst_edge", r_edge, 43);
    check("post_rst_re", r_re, -128);
    check("post_rst_im", r_im, 896);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
